render_sequencer: RTL and testbench

- Sequences one render pass after software sets the do_render control bit.
- Reads a vertex-count header and then the vertex words from SDRAM over an Avalon-MM read master, starting at vertex_buffer_base.
- Assembles the words into whole vertices and streams them to the transform stage with a valid/ready handshake.
- Signals completion so the register block can clear do_render.

---
 rtl/render_sequencer.sv | 169 ++++++++++++++++
 tb/tb_render_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_sequencer.sv
// Render pass sequencer: fetches a vertex-count header and vertex words over Avalon-MM,
// assembles whole vertices and streams them out. Optional cycle counter under RENDER_PERF_EN.
module render_sequencer #(
   parameter int VERTEX_WORDS = 3,
   parameter int MAX_VERTS    = 4096,
   parameter int ADDR_W       = 26
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      do_render,
   input  logic [ADDR_W-1:0]         vertex_buffer_base,
   output logic [ADDR_W-1:0]         avm_address,
   output logic                      avm_read,
   input  logic                      avm_waitrequest,
   input  logic [31:0]               avm_readdata,
   input  logic                      avm_readdatavalid,
   output logic [32*VERTEX_WORDS-1:0] vtx_data,
   output logic                      vtx_valid,
   input  logic                      vtx_ready,
   output logic                      vtx_last,
   output logic                      busy,
   output logic                      render_done,
   output logic [12:0]               verts_sent,
   output logic [2:0]                fsm_state
`ifdef RENDER_PERF_EN
   ,
   output logic [31:0]               perf_cycles
`endif
);

   // Handshake: a vertex transfers on the rising clk edge where vtx_valid && vtx_ready;
   // vtx_data/vtx_last hold steady while vtx_valid is high and vtx_ready is low.
   // A memory request is accepted on the edge where avm_read && !avm_waitrequest.

   localparam int W_W = (VERTEX_WORDS > 1) ? $clog2(VERTEX_WORDS) : 1;
   localparam logic [W_W-1:0] LAST_W = W_W'(VERTEX_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_HDR_REQ    = 3'd1,
      S_HDR_WAIT   = 3'd2,
      S_FETCH_REQ  = 3'd3,
      S_FETCH_WAIT = 3'd4,
      S_EMIT       = 3'd5,
      S_DONE       = 3'd6
   } state_t;

   state_t state, state_next;

   logic              do_prev;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] ptr;
   logic [12:0]       count;
   logic [12:0]       v_idx;
   logic [W_W-1:0]    w_idx;
   logic [31:0]       words [VERTEX_WORDS];

   logic        start;
   logic        hdr_take;
   logic        word_take;
   logic        emit_fire;
   logic [12:0] hdr_count;

   assign start     = (state == S_IDLE) && do_render && !do_prev;
   assign hdr_take  = (state == S_HDR_WAIT) && avm_readdatavalid;
   assign word_take = (state == S_FETCH_WAIT) && avm_readdatavalid;
   assign emit_fire = (state == S_EMIT) && vtx_ready;
   assign hdr_count = (avm_readdata[12:0] > 13'(MAX_VERTS)) ? 13'(MAX_VERTS) : avm_readdata[12:0];

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      avm_read    = 1'b0;
      avm_address = '0;
      vtx_valid   = 1'b0;
      vtx_last    = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) state_next = S_HDR_REQ;
         end
         S_HDR_REQ: begin
            avm_read    = 1'b1;
            avm_address = base_q;
            if (!avm_waitrequest) state_next = S_HDR_WAIT;
         end
         S_HDR_WAIT: begin
            if (avm_readdatavalid) state_next = (hdr_count == 13'd0) ? S_DONE : S_FETCH_REQ;
         end
         S_FETCH_REQ: begin
            avm_read    = 1'b1;
            avm_address = ptr;
            if (!avm_waitrequest) state_next = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            if (avm_readdatavalid) state_next = (w_idx == LAST_W) ? S_EMIT : S_FETCH_REQ;
         end
         S_EMIT: begin
            vtx_valid = 1'b1;
            vtx_last  = (v_idx == count - 13'd1);
            if (vtx_ready) state_next = vtx_last ? S_DONE : S_FETCH_REQ;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ptr walks the word addresses in order, so it equals base + 4 + 4*(v*VERTEX_WORDS + w)
   // and wraps naturally at the address width.
   always_ff @(posedge clk) begin
      if (reset) begin
         do_prev     <= 1'b0;
         base_q      <= '0;
         ptr         <= '0;
         count       <= '0;
         v_idx       <= '0;
         w_idx       <= '0;
         render_done <= 1'b0;
         verts_sent  <= '0;
         for (int i = 0; i < VERTEX_WORDS; i++) words[i] <= '0;
      end else begin
         do_prev     <= do_render;
         render_done <= (state_next == S_DONE);
         if (start) begin
            base_q     <= vertex_buffer_base;
            verts_sent <= '0;
         end
         if (hdr_take) begin
            count <= hdr_count;
            ptr   <= base_q + ADDR_W'(4);
            v_idx <= '0;
            w_idx <= '0;
         end
         if (word_take) begin
            words[w_idx] <= avm_readdata;
            ptr          <= ptr + ADDR_W'(4);
            if (w_idx != LAST_W) w_idx <= w_idx + 1'b1;
         end
         if (emit_fire) begin
            verts_sent <= verts_sent + 13'd1;
            v_idx      <= v_idx + 13'd1;
            w_idx      <= '0;
         end
      end
   end

   for (genvar g = 0; g < VERTEX_WORDS; g++) begin : g_pack
      assign vtx_data[32*g +: 32] = words[g];
   end

   assign fsm_state = state;

`ifdef RENDER_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)                             perf_cycles <= '0;
      else if (start)                        perf_cycles <= '0;
      else if (busy && (perf_cycles != '1))  perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer: a negedge memory/sink responder logs requests and
// vertices, and a single linear initial block checks them against hand-computed values.
module tb_render_sequencer;

   logic        clk;
   logic        reset;
   logic        do_render;
   logic [25:0] vertex_buffer_base;
   logic [25:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [95:0] vtx_data;
   logic        vtx_valid;
   logic        vtx_ready;
   logic        vtx_last;
   logic        busy;
   logic        render_done;
   logic [12:0] verts_sent;
   logic [2:0]  fsm_state;
`ifdef RENDER_PERF_EN
   logic [31:0] perf_cycles;
`endif

   render_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .do_render          (do_render),
      .vertex_buffer_base (vertex_buffer_base),
      .avm_address        (avm_address),
      .avm_read           (avm_read),
      .avm_waitrequest    (avm_waitrequest),
      .avm_readdata       (avm_readdata),
      .avm_readdatavalid  (avm_readdatavalid),
      .vtx_data           (vtx_data),
      .vtx_valid          (vtx_valid),
      .vtx_ready          (vtx_ready),
      .vtx_last           (vtx_last),
      .busy               (busy),
      .render_done        (render_done),
      .verts_sent         (verts_sent),
      .fsm_state          (fsm_state)
`ifdef RENDER_PERF_EN
      ,
      .perf_cycles        (perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controls written only by the main initial block
   int          stall_n;
   int          ready_hold;
   logic [25:0] base_cur;
   logic [31:0] hdr_val;
   bit          mute_fetch;
   bit          stray_rdv;

   // Logs and counters written only by the responder
   int          cyc;
   int          rdv_cyc;
   logic [25:0] aq[$];
   logic [95:0] vq[$];
   bit          lq[$];
   int          stall_cycles, ready_low, addr_err, data_err, b2b_err, valid_cycles, busy_cycles;
   int          wait_cnt, rcnt;
   bit          acc_pend, held_v, prev_fire;
   logic [25:0] acc_addr, req_addr;
   logic [95:0] held_data;

   int passed;
   int total;
   int done_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [25:0] a);
      logic [25:0] off;
      if (a == base_cur) return hdr_val;
      off = a - base_cur - 26'd4;
      return 32'(off >> 2) + 32'd1;
   endfunction

   // Memory slave and vertex sink; drives at negedge so the DUT sees stable inputs at posedge.
   always @(negedge clk) begin
      avm_readdatavalid = 1'b0;
      if (reset) begin
         avm_waitrequest = 1'b0;
         acc_pend        = 1'b0;
         wait_cnt        = 0;
         rcnt            = 0;
         held_v          = 1'b0;
         prev_fire       = 1'b0;
         vtx_ready       = 1'b1;
      end else begin
         if (busy) busy_cycles++;
         if (acc_pend) begin
            acc_pend = 1'b0;
            if (!(mute_fetch && acc_addr != base_cur)) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = mem_word(acc_addr);
               rdv_cyc           = cyc;
            end
         end
         if (stray_rdv) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEAD_BEEF;
         end
         if (avm_read) begin
            if (avm_waitrequest && avm_address != req_addr) addr_err++;
            if (wait_cnt < stall_n) begin
               avm_waitrequest = 1'b1;
               wait_cnt++;
               stall_cycles++;
               req_addr = avm_address;
            end else begin
               avm_waitrequest = 1'b0;
               wait_cnt        = 0;
               acc_pend        = 1'b1;
               acc_addr        = avm_address;
               aq.push_back(avm_address);
            end
         end else begin
            if (avm_waitrequest) addr_err++;
            avm_waitrequest = 1'b0;
         end
         if (vtx_valid) begin
            valid_cycles++;
            if (prev_fire) b2b_err++;
            if (held_v && vtx_data != held_data) data_err++;
            if (rcnt < ready_hold) begin
               vtx_ready = 1'b0;
               rcnt++;
               ready_low++;
               held_v    = 1'b1;
               held_data = vtx_data;
               prev_fire = 1'b0;
            end else begin
               vtx_ready = 1'b1;
               rcnt      = 0;
               held_v    = 1'b0;
               prev_fire = 1'b1;
               vq.push_back(vtx_data);
               lq.push_back(vtx_last);
            end
         end else begin
            vtx_ready = 1'b1;
            held_v    = 1'b0;
            rcnt      = 0;
            prev_fire = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic start_pass(input logic [25:0] b, input logic [31:0] h);
      base_cur           = b;
      hdr_val            = h;
      vertex_buffer_base = b;
      do_render          = 1'b0;
      tick();
      do_render = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      bit found = 1'b0;
      while (!found && n < budget) begin
         tick();
         n++;
         if (render_done) found = 1'b1;
      end
      done_cyc = cyc;
      check("done_seen", 128'(found), 128'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 128'(busy), 128'd0);
      check({tag, "_read"}, 128'(avm_read), 128'd0);
      check({tag, "_addr"}, 128'(avm_address), 128'd0);
      check({tag, "_valid"}, 128'(vtx_valid), 128'd0);
      check({tag, "_last"}, 128'(vtx_last), 128'd0);
      check({tag, "_data"}, 128'(vtx_data), 128'd0);
      check({tag, "_done"}, 128'(render_done), 128'd0);
      check({tag, "_sent"}, 128'(verts_sent), 128'd0);
   endtask

   task automatic check_basic_logs(input string tag, input int a0, input int v0);
      check({tag, "_nreq"}, 128'(aq.size() - a0), 128'd7);
      for (int i = 0; i < 7; i++)
         check({tag, "_addr"}, 128'(aq[a0 + i]), 128'(26'h300000 + 26'(4 * i)));
      check({tag, "_nvtx"}, 128'(vq.size() - v0), 128'd2);
      check({tag, "_vtx0"}, 128'(vq[v0]), 128'(96'h00000003_00000002_00000001));
      check({tag, "_vtx1"}, 128'(vq[v0 + 1]), 128'(96'h00000006_00000005_00000004));
      check({tag, "_last0"}, 128'(lq[v0]), 128'd0);
      check({tag, "_last1"}, 128'(lq[v0 + 1]), 128'd1);
      check({tag, "_sent"}, 128'(verts_sent), 128'd2);
   endtask

   initial begin
      int a0, v0, s0, r0, c0, lasts;
      passed = 0; total = 0;
      reset = 1'b1; do_render = 1'b0; vertex_buffer_base = '0;
      stall_n = 0; ready_hold = 0; base_cur = '0; hdr_val = '0;
      mute_fetch = 1'b0; stray_rdv = 1'b0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; vtx_ready = 1'b1;
      tick(3);
      check_idle_outputs("reset");
      check("reset_state", 128'(fsm_state), 128'd0);
`ifdef RENDER_PERF_EN
      check("reset_perf", 128'(perf_cycles), 128'd0);
`endif
      reset = 1'b0;
      tick(2);

      // Basic pass, do_render then held high throughout
      a0 = aq.size(); v0 = vq.size();
      start_pass(26'h300000, 32'd2);
      check("basic_busy", 128'(busy), 128'd1);
      check("basic_read", 128'(avm_read), 128'd1);
      check("basic_hdr_addr", 128'(avm_address), 128'h300000);
      wait_done(200);
      check_basic_logs("basic", a0, v0);
      check("basic_b2b", 128'(b2b_err), 128'd0);
      tick();
      check("basic_done_pulse", 128'(render_done), 128'd0);
      check("basic_idle", 128'(busy), 128'd0);
`ifdef RENDER_PERF_EN
      check("basic_perf", 128'(perf_cycles), 128'd17);
`endif
      tick(20);
      check("level_one_pass", 128'(aq.size() - a0), 128'd7);
      check("level_idle", 128'(busy), 128'd0);

      // Zero-count header
      a0 = aq.size(); c0 = valid_cycles;
      start_pass(26'h000100, 32'd0);
      wait_done(100);
      check("zero_done_latency", 128'(done_cyc - rdv_cyc), 128'd1);
      check("zero_nreq", 128'(aq.size() - a0), 128'd1);
      check("zero_no_valid", 128'(valid_cycles - c0), 128'd0);
      check("zero_sent", 128'(verts_sent), 128'd0);

      // Waitrequest and vtx_ready stalls
      stall_n = 3; ready_hold = 5;
      a0 = aq.size(); v0 = vq.size(); s0 = stall_cycles; r0 = ready_low;
      start_pass(26'h300000, 32'd2);
      wait_done(400);
      check_basic_logs("stall", a0, v0);
      check("stall_cycles", 128'(stall_cycles - s0), 128'd21);
      check("stall_ready_low", 128'(ready_low - r0), 128'd10);
      check("stall_addr_held", 128'(addr_err), 128'd0);
      check("stall_data_held", 128'(data_err), 128'd0);
      stall_n = 0; ready_hold = 0;
      tick(3);

      // Address wrap, with do_render toggling while busy and ending high
      a0 = aq.size(); v0 = vq.size();
      start_pass(26'h3FFFFFC, 32'd1);
      do_render = 1'b0; tick();
      do_render = 1'b1; tick();
      do_render = 1'b0; tick();
      do_render = 1'b1;
      wait_done(100);
      check("wrap_nreq", 128'(aq.size() - a0), 128'd4);
      check("wrap_hdr", 128'(aq[a0]), 128'h3FFFFFC);
      check("wrap_a1", 128'(aq[a0 + 1]), 128'h0000000);
      check("wrap_a2", 128'(aq[a0 + 2]), 128'h0000004);
      check("wrap_a3", 128'(aq[a0 + 3]), 128'h0000008);
      check("wrap_vtx", 128'(vq[v0]), 128'(96'h00000003_00000002_00000001));
      check("wrap_last", 128'(lq[v0]), 128'd1);
      tick(10);
      check("toggle_no_pass", 128'(aq.size() - a0), 128'd4);
      check("toggle_idle", 128'(busy), 128'd0);

      // Clamp: header bits above [12:0] ignored, 13'h1FFF clamps to 4096
      a0 = aq.size(); v0 = vq.size();
      start_pass(26'h200000, 32'hFFFF_FFFF);
      check("restart_busy", 128'(busy), 128'd1);
      wait_done(40000);
      check("clamp_nvtx", 128'(vq.size() - v0), 128'd4096);
      check("clamp_sent", 128'(verts_sent), 128'd4096);
      check("clamp_nreq", 128'(aq.size() - a0), 128'd12289);
      check("clamp_last_addr", 128'(aq[aq.size() - 1]), 128'h20C000);
      lasts = 0;
      for (int i = v0; i < vq.size(); i++) lasts += int'(lq[i]);
      check("clamp_one_last", 128'(lasts), 128'd1);
      check("clamp_last_flag", 128'(lq[vq.size() - 1]), 128'd1);
      check("clamp_b2b", 128'(b2b_err), 128'd0);
      tick(3);

      // Reset while stuck in FETCH_WAIT, then a stray readdatavalid
      mute_fetch = 1'b1;
      a0 = aq.size();
      start_pass(26'h300000, 32'd2);
      tick(15);
      check("stuck_busy", 128'(busy), 128'd1);
      check("stuck_read", 128'(avm_read), 128'd0);
      check("stuck_nreq", 128'(aq.size() - a0), 128'd2);
      do_render = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mute_fetch = 1'b0;
      check_idle_outputs("midreset");
      stray_rdv = 1'b1;
      tick();
      stray_rdv = 1'b0;
      tick(3);
      check("stray_busy", 128'(busy), 128'd0);
      check("stray_valid", 128'(vtx_valid), 128'd0);
      check("stray_read", 128'(avm_read), 128'd0);
      check("stray_nreq", 128'(aq.size() - a0), 128'd2);

      // do_render already high when reset releases starts a pass
      base_cur = 26'h000100; hdr_val = 32'd0; vertex_buffer_base = 26'h000100;
      do_render = 1'b1;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      check("release_start", 128'(busy), 128'd1);
      wait_done(100);
      check("release_sent", 128'(verts_sent), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
